// File: rtl/sync_arb_pkg.sv
// Shared types and the round-robin selection helper for sync_req_arbiter.
package sync_arb_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_TIMEOUT = 16;
  localparam int unsigned MAX_REQ     = 8;
  localparam int unsigned MAX_ID_W    = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } rr_pick_t;

  // Searches last+1, last+2, ... modulo num_req and returns the first pending line.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]  pending,
                                       input logic [MAX_ID_W-1:0] last,
                                       input int unsigned         num_req);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      cand = (32'(last) + k) % num_req;
      if (k <= num_req && !res.found && pending[cand[MAX_ID_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[MAX_ID_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/req_edge_sync.sv
// Two-flop synchronizer for one asynchronous request line, followed by a
// history flop that turns each 0->1 transition into a single-cycle pulse.
module req_edge_sync (
  input  logic clk,
  input  logic n_rst,
  input  logic async_i,
  output logic edge_pulse_o
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign edge_pulse_o = sync_q & ~hist_q;

endmodule

// File: rtl/sync_req_arbiter.sv
// Round-robin arbiter granting one owner at a time to NUM_REQ asynchronous
// requesters; the owner releases on done or is forced off after TIMEOUT cycles.
module sync_req_arbiter
  import sync_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [NUM_REQ-1:0] async_req,
  input  logic               done,
  input  logic               clr_err,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               timeout_err,
  output logic [NUM_REQ-1:0] overrun
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [NUM_REQ-1:0] edge_pulse;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_sync
    req_edge_sync u_sync (
      .clk          (clk),
      .n_rst        (n_rst),
      .async_i      (async_req[i]),
      .edge_pulse_o (edge_pulse[i])
    );
  end

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] overrun_q, overrun_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               terr_q, terr_d;
  logic [NUM_REQ-1:0] grant_now;
  logic [MAX_REQ-1:0] pend_ext;
  rr_pick_t           pick;

  assign pend_ext = MAX_REQ'(pending_q);
  assign pick     = rr_pick(pend_ext, MAX_ID_W'(last_q), NUM_REQ);

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    terr_d     = 1'b0;
    grant_now  = '0;

    case (state_q)
      IDLE: begin
        if (pick.found) begin
          grant_now  = NUM_REQ'(1) << pick.idx;
          grant_d    = grant_now;
          grant_id_d = ID_W'(pick.idx);
          cnt_d      = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        // done takes precedence over a timeout landing on the same edge.
        if (done || cnt_q == CNT_W'(TIMEOUT - 1)) begin
          terr_d     = ~done;
          grant_d    = '0;
          grant_id_d = '0;
          last_d     = grant_id_q;
          cnt_d      = '0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    // A fresh edge on the line being granted re-arms it rather than overrunning.
    pending_d = edge_pulse | (pending_q & ~grant_now);
    overrun_d = (edge_pulse & pending_q & ~grant_now) | (overrun_q & ~{NUM_REQ{clr_err}});
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      overrun_q  <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_q     <= ID_W'(NUM_REQ - 1);
      cnt_q      <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      terr_q     <= terr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign busy        = (state_q == BUSY);
  assign timeout_err = terr_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_sync_req_arbiter.sv
// Self-checking bench for sync_req_arbiter: directed scenarios followed by
// random traffic, all compared cycle by cycle against a behavioural model.
module tb_sync_req_arbiter;

  localparam int N  = 4;
  localparam int T  = 16;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          n_rst = 1'b1;
  logic [N-1:0]  async_req = '0;
  logic          done = 1'b0;
  logic          clr_err = 1'b0;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_id;
  logic          busy;
  logic          timeout_err;
  logic [N-1:0]  overrun;

  sync_req_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (T)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .async_req   (async_req),
    .done        (done),
    .clr_err     (clr_err),
    .grant       (grant),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model: line samples per clock edge (index 0 newest), pending/overrun
  // flags, current owner (-1 = none), last served line, grant start cycle.
  bit smp [N][3];
  bit m_pend [N];
  bit m_ovr [N];
  int m_owner;
  int m_last;
  int m_start;
  int m_cyc = 0;
  bit m_terr;

  int           gseq [$];
  int           gcount [N];
  int           terr_seen;
  logic [N-1:0] prev_grant = '0;
  int           lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      smp[i][0] = 1'b0; smp[i][1] = 1'b0; smp[i][2] = 1'b0;
      m_pend[i] = 1'b0;
      m_ovr[i]  = 1'b0;
    end
    m_owner = -1;
    m_last  = N - 1;
    m_terr  = 1'b0;
  endfunction

  function automatic void model_step();
    bit pulse [N];
    bit hit;
    int won;
    m_cyc++;
    won = -1;
    // A 0->1 seen at edge k reaches the pending flags at edge k+2.
    for (int i = 0; i < N; i++) pulse[i] = smp[i][1] && !smp[i][2];
    m_terr = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (won < 0 && m_pend[(m_last + k) % N]) won = (m_last + k) % N;
      end
      if (won >= 0) begin
        m_owner = won;
        m_start = m_cyc;
      end
    end else if (done) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (m_cyc - m_start == T) begin
      m_last  = m_owner;
      m_owner = -1;
      m_terr  = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      hit       = (i == won);
      m_ovr[i]  = (pulse[i] && m_pend[i] && !hit) || (m_ovr[i] && !clr_err);
      m_pend[i] = pulse[i] || (m_pend[i] && !hit);
      smp[i][2] = smp[i][1];
      smp[i][1] = smp[i][0];
      smp[i][0] = async_req[i];
    end
  endfunction

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic logic [N-1:0] exp_ovr();
    logic [N-1:0] o = '0;
    for (int i = 0; i < N; i++) o[i] = m_ovr[i];
    return o;
  endfunction

  function automatic bit quiet();
    if (m_owner >= 0) return 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_pend[i]) return 1'b0;
      if (smp[i][0] != async_req[i] || smp[i][1] != smp[i][0] || smp[i][2] != smp[i][1])
        return 1'b0;
    end
    return 1'b1;
  endfunction

  // Grant order packed as decimal digits of (id+1), e.g. 1,3 -> 24.
  function automatic int seq_code();
    int code = 0;
    foreach (gseq[k]) code = code * 10 + gseq[k] + 1;
    return code;
  endfunction

  task automatic step_cycle();
    @(posedge clk);
    if (n_rst) model_step();
    else model_reset();
    @(negedge clk);
    check("grant", grant, exp_grant());
    check("grant_id", grant_id, (m_owner < 0) ? 0 : m_owner);
    check("busy", busy, m_owner >= 0);
    check("timeout_err", timeout_err, m_terr);
    check("overrun", overrun, exp_ovr());
    check("grant_onehot0", $onehot0(grant), 1);
    if (grant !== '0 && prev_grant === '0) gseq.push_back(int'(grant_id));
    for (int i = 0; i < N; i++) if (grant[i] === 1'b1) gcount[i]++;
    if (timeout_err === 1'b1) terr_seen++;
    prev_grant = grant;
  endtask

  task automatic clear_stats();
    gseq.delete();
    for (int i = 0; i < N; i++) gcount[i] = 0;
    terr_seen = 0;
  endtask

  task automatic do_reset(input logic [N-1:0] hold_req);
    async_req = hold_req;
    done      = 1'b0;
    clr_err   = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    check("rst_grant", grant, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_overrun", overrun, 0);
    model_reset();
    repeat (2) step_cycle();
    n_rst = 1'b1;
  endtask

  task automatic pulse_lines(input logic [N-1:0] m);
    async_req = m;
    step_cycle();
    async_req = '0;
    step_cycle();
  endtask

  // hold = cycles each grant is kept before done; 0 means never assert done.
  task automatic serve_all(input int hold, input int budget);
    for (int c = 0; c < budget && !quiet(); c++) begin
      done = (m_owner >= 0) && (hold > 0) && ((m_cyc + 1 - m_start) == hold);
      step_cycle();
    end
    done = 1'b0;
    check("serve_idle", busy, 0);
  endtask

  task automatic wait_owner(input int who, input int budget);
    logic [N-1:0] want;
    want = '0;
    want[who] = 1'b1;
    for (int c = 0; c < budget && m_owner != who; c++) step_cycle();
    check("wait_owner", grant, want);
  endtask

  initial begin
    model_reset();
    clear_stats();

    // Lines held high through reset: first grant 3 cycles after the first sampled edge.
    do_reset('1);
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      step_cycle();
      if (grant !== '0) begin
        lat = c;
        break;
      end
    end
    check("reset_latency_edges", lat, 4);
    check("first_grant", grant, 4'b0001);
    check("first_busy", busy, 1);
    serve_all(2, 100);
    check("rotation_order", seq_code(), 1234);
    async_req = '0;
    serve_all(2, 20);

    // Single request, done after 5 busy cycles.
    clear_stats();
    pulse_lines(4'b0100);
    serve_all(5, 60);
    check("single_order", seq_code(), 3);
    check("single_len", gcount[2], 5);
    check("single_no_terr", terr_seen, 0);

    // Lines 1 and 3 together from reset pointer, twice; then 0 and 3 after serving 0.
    do_reset('0);
    clear_stats();
    pulse_lines(4'b1010);
    serve_all(2, 60);
    check("rr_13_first", seq_code(), 24);
    clear_stats();
    pulse_lines(4'b1010);
    serve_all(2, 60);
    check("rr_13_second", seq_code(), 24);
    clear_stats();
    pulse_lines(4'b0001);
    serve_all(2, 60);
    clear_stats();
    pulse_lines(4'b1001);
    serve_all(2, 60);
    check("rr_30_order", seq_code(), 41);

    // Timeout release versus done on the final cycle.
    clear_stats();
    pulse_lines(4'b0100);
    serve_all(0, 80);
    check("timeout_len", gcount[2], T);
    check("timeout_err_pulses", terr_seen, 1);
    clear_stats();
    pulse_lines(4'b0100);
    serve_all(T, 80);
    check("done_at_limit_len", gcount[2], T);
    check("done_at_limit_no_err", terr_seen, 0);

    // Overrun on line 1 while line 0 owns the resource.
    clear_stats();
    async_req = 4'b0001;
    step_cycle();
    async_req = '0;
    wait_owner(0, 10);
    async_req = 4'b0010; step_cycle();
    async_req = '0;      step_cycle();
    async_req = 4'b0010; step_cycle();
    async_req = '0;      step_cycle();
    step_cycle();
    check("ovr_set", overrun, 4'b0010);
    clr_err = 1'b1; step_cycle(); clr_err = 1'b0;
    check("ovr_cleared", overrun, 4'b0000);
    async_req = 4'b0010; step_cycle();
    async_req = '0;      step_cycle();
    clr_err = 1'b1; step_cycle(); clr_err = 1'b0;
    check("ovr_set_beats_clear", overrun, 4'b0010);
    step_cycle();
    check("ovr_sticky", overrun, 4'b0010);
    done = 1'b1; step_cycle(); done = 1'b0;
    serve_all(3, 60);
    clr_err = 1'b1; step_cycle(); clr_err = 1'b0;

    // Line 0 re-requests on the very edge it is granted.
    clear_stats();
    async_req = 4'b1000;
    step_cycle();
    async_req = '0;
    wait_owner(3, 10);
    async_req = 4'b0011; step_cycle();
    async_req = '0;
    repeat (4) step_cycle();
    async_req = 4'b0001; step_cycle();
    async_req = '0;
    done = 1'b1; step_cycle(); done = 1'b0;
    step_cycle();
    check("regrant_line0", grant, 4'b0001);
    check("regrant_no_overrun", overrun[0], 0);
    serve_all(2, 80);
    check("regrant_order", seq_code(), 4121);

    // Random traffic with a reset in the middle.
    for (int c = 0; c < 2000; c++) begin
      if (c == 1000) do_reset(async_req);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) async_req[i] = ~async_req[i];
      done    = (m_owner >= 0) && ($urandom_range(0, 7) == 0);
      clr_err = ($urandom_range(0, 31) == 0);
      step_cycle();
    end
    done    = 1'b0;
    clr_err = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_req_arbiter.md
Name: sync_req_arbiter

Overview:
- Round-robin arbiter that shares one single-owner resource (e.g. a shared serial/datapath engine) between NUM_REQ requesters whose request lines are asynchronous to clk.
- Each request line passes through a two-flop low-reset synchronizer and a rising-edge detector, then is latched as a pending request.
- An IDLE/BUSY state machine grants one requester at a time and waits for done or a timeout.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 16, max cycles in BUSY before forced release (>=2)
ID_W, $clog2(NUM_REQ), width of grant_id

Ports:
clk  in  1  system clock
n_rst  in  1  reset; one clock, asynchronous active-low reset, all flops cleared on negedge n_rst
async_req  in  NUM_REQ  asynchronous request lines, one per requester; rising edge = one request
done  in  1  synchronous; resource finished current job
clr_err  in  1  synchronous; clears overrun flags
grant  out  NUM_REQ  one-hot grant, registered
grant_id  out  ID_W  index of granted requester, registered
busy  out  1  high while in BUSY
timeout_err  out  1  one-cycle pulse on forced release
overrun  out  NUM_REQ  sticky per-line flag: request edge arrived while already pending

Behaviour:
- Reset: every output is 0; all synchronizer and edge flops are 0; pending = 0; state = IDLE; timeout count = 0; last-served pointer = NUM_REQ-1, so requester 0 has first priority.
- Sync/edge per line: two flops reset low, plus one history flop. edge_pulse[i] = sync[i] & ~hist[i], high for exactly one cycle per 0->1 transition. A high level held on the line produces only one pulse.
- Request latency: async rising edge captured at clk edge k (setup met) -> pending[i] = 1 after edge k+2 -> grant visible after edge k+3, if IDLE and the line wins.
- Pending set/clear: pending[i] is set by edge_pulse[i] and cleared at the clk edge that issues grant to i. If the set and clear coincide, set wins: pending stays 1 and overrun is not set.
- Overrun: if edge_pulse[i] arrives while pending[i] = 1 and i is not being granted that edge, set overrun[i]. clr_err clears all overrun bits; if a set coincides with clr_err, the set wins.
- FSM IDLE:
  - If any pending bit is set, select the winner by searching last+1, last+2, ... with wrap-around modulo NUM_REQ.
  - At that edge: register grant = onehot(winner) and grant_id = winner, clear pending[winner], reset the counter to 0, go to BUSY.
  - done is ignored in IDLE.
- FSM BUSY:
  - busy = 1; grant and grant_id are held stable; the counter increments each cycle.
  - If done = 1: grant = 0, grant_id = 0, last = grant_id, go to IDLE.
  - Else if counter == TIMEOUT-1: same release, plus timeout_err = 1 for the next cycle.
  - done and timeout on the same edge: done wins, no error.
- Rearbitration: at least one IDLE cycle separates consecutive grants. Grant-to-grant spacing is therefore at least 2 cycles after done.
- Fairness: with all lines continuously re-requesting, grants rotate 0,1,2,3,0...
- Reset mid-operation: asynchronously forces the reset values above. Pending requests and overrun are lost. A line held high through reset produces a new pulse after reset deasserts, because its sync and history flops start at 0.
- Invariants:
  - grant is always zero or one-hot.
  - grant != 0 if and only if busy = 1.
  - The counter never exceeds TIMEOUT-1.

Decomposition:
- Package sync_arb_pkg:
  - typedef enum logic {IDLE, BUSY} arb_state_t
  - localparam default NUM_REQ/TIMEOUT
  - function rr_pick(pending, last) returning winner index and found flag
- Sub-module req_edge_sync: 1-bit two-flop low-reset synchronizer plus history flop, output edge_pulse. Instantiated NUM_REQ times via generate.
- Top level holds the pending/overrun registers, the FSM, the counter and the RR pointer.

Test Plan:
- Reset with async_req = 4'b1111 held: all outputs 0 during reset. After release, grant = 4'b0001 appears exactly 3 cycles after the first sampled clk edge, and busy = 1.
- Single request on line 2, done pulsed after 5 BUSY cycles: grant = 4'b0100, grant_id = 2 for 5 cycles, then grant = 0 and busy = 0 the next cycle. No timeout_err.
- Requests on lines 1 and 3 simultaneously, last = 3 (reset): grant order is 1 then 3. Repeated next round with last = 3: order is 1, 3 again. With lines 0 and 3 after serving 0: 3 is granted before 0.
- No done while granted, TIMEOUT = 16: grant held exactly 16 cycles, then released with timeout_err high 1 cycle. done asserted on cycle 16 instead: no error.
- Line 1 pending, second rising edge on line 1 before grant: overrun = 4'b0010 stays set until clr_err; clr_err coinciding with a new overrun event leaves bit 1 set.
- Line 0 edge_pulse on the same edge it is granted: pending[0] stays 1, overrun stays 0, and line 0 is granted again after its release once the other lines are served.
